uart_frame_parser: RTL and testbench

Downstream consumer of the UART receive path. It drains bytes from the RX FIFO read port (`rx_empty`/`rd_en`/`data_out`) and hunts for a start-of-frame byte. It validates length and checksum, buffers the payload, and releases only good frames on a valid/ready byte stream. Bad frames are dropped and reported on an error pulse with a code.

---
 rtl/uart_frame_parser_if.sv | 25 ++
 rtl/uart_frame_parser.sv | 161 ++++++++++++++++
 tb/tb_uart_frame_parser.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_parser_if.sv
// rtl/uart_frame_parser_if.sv - RX FIFO read port, payload byte stream and frame status for uart_frame_parser.
interface uart_frame_parser_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_empty;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rd_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_last;
  logic                 frame_ok;
  logic                 frame_err;
  logic [1:0]           err_code;

  modport master (
    input  rx_empty, rx_data, out_ready,
    output rd_en, out_valid, out_data, out_last, frame_ok, frame_err, err_code
  );

  modport slave (
    output rx_empty, rx_data, out_ready,
    input  rd_en, out_valid, out_data, out_last, frame_ok, frame_err, err_code
  );
endinterface

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - SOF/LEN/payload/CHK frame parser draining a UART RX FIFO.
// Optional inter-byte timeout enabled by UART_FRAME_PARSER_TIMEOUT_EN.
module uart_frame_parser #(
  parameter int                   DATA_BITS      = 8,
  parameter int                   MAX_LEN        = 16,
  parameter logic [DATA_BITS-1:0] SOF            = 8'hA5,
  parameter int                   TIMEOUT_CYCLES = 1024
) (
  input logic                 clk,
  input logic                 reset,
  uart_frame_parser_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_EMIT} state_t;

  localparam int                   IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [DATA_BITS-1:0] MAX_LEN_W = DATA_BITS'(MAX_LEN);

  state_t               state, state_next;
  logic                 rd_en_q, rd_en_d, cap;
  logic [DATA_BITS-1:0] len_q, idx_q, acc_q;
  logic [DATA_BITS-1:0] payload_buf [MAX_LEN];
  logic                 ok_d, err_d;
  logic [1:0]           code_d;
  logic                 frame_ok_q, frame_err_q;
  logic [1:0]           err_code_q;
  logic                 tmo_hit;
  logic                 busy;
  logic                 last_idx;
  logic                 reading_next;

  assign busy     = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
  assign last_idx = (idx_q == len_q - 1'b1);

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (busy && !cap && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo_hit = busy && !cap && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  // No counter: a stalled frame waits forever, so this never fires.
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_next = state;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    code_d     = err_code_q;
    case (state)
      S_IDLE: begin
        if (cap && bus.rx_data == SOF) state_next = S_LEN;
      end
      S_LEN: begin
        if (cap) begin
          if (bus.rx_data == '0 || bus.rx_data > MAX_LEN_W) begin
            state_next = S_IDLE;
            err_d      = 1'b1;
            code_d     = 2'b01;
          end else begin
            state_next = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (cap && last_idx) state_next = S_CHK;
      end
      S_CHK: begin
        if (cap) begin
          if (bus.rx_data == acc_q) begin
            state_next = S_EMIT;
            ok_d       = 1'b1;
          end else begin
            state_next = S_IDLE;
            err_d      = 1'b1;
            code_d     = 2'b10;
          end
        end
      end
      S_EMIT: begin
        if (bus.out_ready && last_idx) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (tmo_hit) begin
      state_next = S_IDLE;
      err_d      = 1'b1;
      code_d     = 2'b11;
    end
  end

  // Read decision looks at the next state so no strobe leaks into EMIT.
  assign reading_next = (state_next != S_EMIT);
  assign rd_en_d      = reading_next && !bus.rx_empty && !rd_en_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      rd_en_q     <= 1'b0;
      cap         <= 1'b0;
      len_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state       <= state_next;
      rd_en_q     <= rd_en_d;
      cap         <= rd_en_q;
      frame_ok_q  <= ok_d;
      frame_err_q <= err_d;
      err_code_q  <= code_d;
      case (state)
        S_LEN: begin
          if (cap && state_next == S_PAYLOAD) begin
            len_q <= bus.rx_data;
            acc_q <= bus.rx_data;
            idx_q <= '0;
          end
        end
        S_PAYLOAD: begin
          if (cap) begin
            acc_q <= acc_q + bus.rx_data;
            idx_q <= idx_q + 1'b1;
          end
        end
        S_CHK: begin
          if (state_next == S_EMIT) idx_q <= '0;
        end
        S_EMIT: begin
          if (bus.out_ready) idx_q <= last_idx ? '0 : idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_PAYLOAD && cap) payload_buf[idx_q[IW-1:0]] <= bus.rx_data;
  end

  assign bus.rd_en     = rd_en_q;
  assign bus.out_valid = (state == S_EMIT);
  assign bus.out_data  = (state == S_EMIT) ? payload_buf[idx_q[IW-1:0]] : '0;
  assign bus.out_last  = (state == S_EMIT) && last_idx;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - directed self-checking bench for uart_frame_parser with a model RX FIFO.
module tb_uart_frame_parser;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_frame_parser_if #(.DATA_BITS(8)) bus ();

  uart_frame_parser #(
    .DATA_BITS(8), .MAX_LEN(16), .SOF(8'hA5), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [7:0] fifo [$];
  int         underflow = 0;

  // Standard-mode FIFO: dout valid the cycle after rd_en
  always @(posedge clk) begin
    if (bus.rd_en) begin
      if (fifo.size() == 0) underflow++;
      else bus.rx_data <= fifo.pop_front();
    end
    bus.rx_empty <= (fifo.size() == 0);
  end

  int         n_ok = 0, n_err = 0, n_rd_emit = 0, n_misalign = 0;
  logic [1:0] last_code = 2'b00;
  logic [8:0] outq [$];

  always @(negedge clk) begin
    if (bus.frame_ok) begin
      n_ok++;
      if (!bus.out_valid) n_misalign++;
    end
    if (bus.frame_err) begin
      n_err++;
      last_code = bus.err_code;
    end
    if (bus.out_valid && bus.out_ready) outq.push_back({bus.out_last, bus.out_data});
    if (bus.out_valid && bus.rd_en) n_rd_emit++;
  end

  int total = 0, bad = 0;
  int b_ok, b_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] bytes, input int n);
    for (int i = n - 1; i >= 0; i--) fifo.push_back(bytes[8*i +: 8]);
  endtask

  task automatic snap();
    b_ok  = n_ok;
    b_err = n_err;
    outq.delete();
  endtask

  function automatic logic [8:0] oq(input int i);
    return (i < outq.size()) ? outq[i] : 9'h1ff;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    logic hold_ok;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    cyc(3);
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_err_code", bus.err_code, 0);
    reset = 1'b0;
    cyc(2);

    // good frame
    snap();
    push(64'hA5_03_11_22_33_69, 6);
    cyc(40);
    check("good_ok", n_ok - b_ok, 1);
    check("good_err", n_err - b_err, 0);
    check("good_cnt", outq.size(), 3);
    check("good_b0", oq(0), 9'h011);
    check("good_b1", oq(1), 9'h022);
    check("good_b2", oq(2), 9'h133);

    // bad checksum, then good frame
    snap();
    push(64'hA5_02_10_20_33, 5);
    cyc(30);
    check("chk_err", n_err - b_err, 1);
    check("chk_code", last_code, 2'b10);
    check("chk_noout", outq.size(), 0);
    push(64'hA5_01_7E_7F, 4);
    cyc(30);
    check("chk_next_ok", n_ok - b_ok, 1);
    check("chk_next_b0", oq(0), 9'h17E);

    // garbage, zero length, oversize length
    snap();
    push(64'h00_FF_5A, 3);
    cyc(20);
    check("garbage_err", n_err - b_err, 0);
    push(64'hA5_00_A5_11, 4);
    cyc(30);
    check("len_err", n_err - b_err, 2);
    check("len_code", last_code, 2'b01);
    check("len_ok", n_ok - b_ok, 0);

    // backpressure on byte 2, FIFO kept non-empty during EMIT
    snap();
    push(64'hA5_03_11_22_33_69, 6);
    push(64'h00_00_FF, 3);
    k = 0;
    while (!(bus.out_valid && bus.out_data == 8'h22) && k < 100) begin
      cyc(1);
      k++;
    end
    check("bp_reach", k < 100, 1);
    bus.out_ready = 1'b0;
    hold_ok = 1'b1;
    repeat (5) begin
      cyc(1);
      if (bus.out_data !== 8'h22 || bus.out_valid !== 1'b1 || bus.out_last !== 1'b0) hold_ok = 1'b0;
    end
    check("bp_hold", hold_ok, 1);
    bus.out_ready = 1'b1;
    cyc(30);
    check("bp_cnt", outq.size(), 3);
    check("bp_b1", oq(1), 9'h022);
    check("bp_b2", oq(2), 9'h133);
    check("bp_ok", n_ok - b_ok, 1);
    check("bp_err", n_err - b_err, 0);
    check("bp_rd_emit", n_rd_emit, 0);

    // stalled frame
    snap();
    push(64'hA5_03_11, 3);
    cyc(1100);
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
    check("tmo_err", n_err - b_err, 1);
    check("tmo_code", last_code, 2'b11);
    push(64'h22_33_69, 3);
    cyc(20);
    check("tmo_ok", n_ok - b_ok, 0);
`else
    check("stall_err", n_err - b_err, 0);
    push(64'h22_33_69, 3);
    cyc(30);
    check("stall_ok", n_ok - b_ok, 1);
    check("stall_cnt", outq.size(), 3);
    check("stall_b2", oq(2), 9'h133);
`endif

    // reset mid-frame
    snap();
    push(64'hA5_03_11, 3);
    cyc(10);
    reset = 1'b1;
    #1;
    check("mid_rst_rd_en", bus.rd_en, 0);
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_last", bus.out_last, 0);
    check("mid_rst_pulses", {bus.frame_ok, bus.frame_err}, 0);
    check("mid_rst_data", bus.out_data, 0);
    check("mid_rst_code", bus.err_code, 0);
    cyc(2);
    reset = 1'b0;
    push(64'h22_33_69, 3);
    cyc(30);
    check("mid_ign_ok", n_ok - b_ok, 0);
    check("mid_ign_err", n_err - b_err, 0);
    push(64'hA5_01_7E_7F, 4);
    cyc(30);
    check("mid_next_ok", n_ok - b_ok, 1);
    check("mid_next_b0", oq(0), 9'h17E);

    check("underflow", underflow, 0);
    check("ok_align", n_misalign, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
